mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory-stage load/store unit between the pipeline's M stage (ALU address, store data, load result) and a data-memory port that uses a request/grant plus read-valid handshake.
- Formats stores into byte strobes and lane-replicated data.
- Aligns and extends load data.
- Detects misaligned accesses.
- Holds the pipeline with stallM until the memory transaction completes.

Parameters:
- TIMEOUT, 255: max cycles waiting in REQ+WAIT before a bus error; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  M stage holds a load/store.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10/11 word.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  32  byte address (aluoutM).
- req_wdata  in  32  store data (writedataM).
- stallM  out  1  hold F/D/E/M stages.
- rdata  out  32  aligned/extended load result for W.
- done  out  1  one-cycle transaction-complete pulse.
- adel  out  1  misaligned load.
- ades  out  1  misaligned store.
- buserr  out  1  watchdog expired, one-cycle pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_wstrb  out  4  byte enables.
- mem_addr  out  32  word address, bits [1:0] = 00.
- mem_wdata  out  32  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  raw read word.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: stallM, done, adel, ades, buserr, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rdata. Watchdog counter 0.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - adel = req_valid & misaligned & ~req_we, combinational.
  - ades = req_valid & misaligned & req_we, combinational.
  - No memory access is issued and stallM stays 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On req_valid & aligned: latch we, size, unsigned and addr[1:0]; register mem_addr, mem_we, mem_wstrb, mem_wdata; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1; all mem_* outputs held stable until grant.
  - On mem_gnt: drop mem_req next cycle; store goes to DONE, load goes to WAIT.
- WAIT:
  - On mem_rvalid: register the formatted load data into rdata; go to DONE.
  - mem_rvalid in the same cycle as the grant is not used.
- DONE:
  - done=1 for one cycle; go to IDLE.
  - rdata holds until the next load capture.
- stallM = req_valid & aligned & (state != DONE). This gives a minimum access latency of 3 cycles for a store and 4 for a load with zero-wait memory. The pipeline advances on the DONE cycle, and IDLE samples the next instruction.
- Watchdog:
  - The counter increments each cycle in REQ or WAIT and clears in IDLE.
  - When it reaches TIMEOUT: drop mem_req, set rdata=0, go to DONE with buserr=1 alongside done.
  - A late mem_gnt or mem_rvalid arriving in IDLE or DONE is ignored.
- Store formatting (addr[1:0]=a):
  - Byte: wstrb = 0001<<a; wdata = {4{wd[7:0]}}.
  - Half: wstrb = 0011 (a=0) or 1100 (a=2); wdata = {2{wd[15:0]}}.
  - Word: wstrb = 1111; wdata = wd.
- Load formatting:
  - Byte: lane mem_rdata[8a+7:8a].
  - Half: lane [15:0] (a=0) or [31:16] (a=2).
  - Byte and half are sign-extended unless req_unsigned; word is passed through.
- Loads drive mem_wstrb=0000.
- req_* inputs are don't-care outside IDLE; the latched copy is used.
- Reset mid-transaction: immediate return to IDLE and mem_req=0. Memory-side abort is the memory's responsibility.

Decomposition:
- Shared defines header lsu_defines: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10) and state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3).
- One combinational sub-module, lsu_align, computes misaligned, wstrb, lane-replicated wdata and the extended load result. The FSM, watchdog and registers stay in mem_lsu.

Test Plan:
- Store byte (zero-wait memory): addr=0x1002, wd=0x000000AB → mem_addr=0x1000, wstrb=0100, wdata=0xABABABAB, stallM=1 for 2 cycles, then done.
- Load half, signed and unsigned, with 2-cycle gnt latency and 1-cycle rvalid latency: addr=0x2002, mem_rdata=0x8001FFFF.
  - Signed → rdata=0xFFFF8001.
  - Unsigned → rdata=0x00008001.
  - In both cases stallM=1 until DONE.
- Misaligned:
  - Word load at addr=0x3001 → adel=1, mem_req never asserted, stallM=0.
  - Half store at addr=0x3003 → ades=1.
- Watchdog: TIMEOUT=8, mem_gnt held 0 → buserr and done pulse after 8 cycles in REQ, rdata=0. A late mem_rvalid is ignored.
- Back-to-back: lw 0x10 then sw 0x14 with req_valid continuous → exactly one mem_req grant per instruction, done pulses twice, and the second request starts in IDLE the cycle after the first DONE.
- Reset asserted in WAIT → all outputs 0 asynchronously. After release, a new lw completes normally.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared size and state encodings for the memory-stage load/store unit
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - combinational store lane formatting, misalignment check and load extension
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic        o_misaligned,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_misaligned = 1'b0;
    o_wstrb      = 4'b1111;
    o_wdata      = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_misaligned = i_addr_lo[0];
        o_wstrb      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

  // Load side uses the latched request, since the live req_* may have moved on.
  always_comb begin
    w_byte    = i_rdata[7:0];
    w_half    = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_ld_data = i_rdata;
    case (i_ld_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-stage load/store unit: request/grant FSM, watchdog and pipeline stall
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stallM,
  output logic [31:0] rdata,
  output logic        done,
  output logic        adel,
  output logic        ades,
  output logic        buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [1:0]       r_addr_lo;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [3:0]       r_mem_wstrb;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_rdata;
  logic             r_done;
  logic             r_buserr;

  logic             w_misaligned;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ld_data;
  logic             w_go;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout;

  mem_lsu_align u_align (
    .i_size        (req_size),
    .i_addr_lo     (req_addr[1:0]),
    .i_wdata       (req_wdata),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_addr_lo  (r_addr_lo),
    .i_rdata       (mem_rdata),
    .o_misaligned  (w_misaligned),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .o_ld_data     (w_ld_data)
  );

  // Combinational outputs are gated by reset so every output reads 0 while held in reset.
  assign w_go   = rst & req_valid & ~w_misaligned;
  assign adel   = rst & req_valid & w_misaligned & ~req_we;
  assign ades   = rst & req_valid & w_misaligned & req_we;
  assign stallM = w_go & (r_state != DONE);

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT));

  assign rdata     = r_rdata;
  assign done      = r_done;
  assign buserr    = r_buserr;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'b0000;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_done      <= 1'b0;
      r_buserr    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_buserr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_go) begin
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_addr_lo   <= req_addr[1:0];
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_we    <= req_we;
            r_mem_wstrb <= req_we ? w_wstrb : 4'b0000;
            r_mem_wdata <= w_wdata;
            r_mem_req   <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          r_cnt <= w_cnt_nxt;
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_done    <= r_mem_we;
            r_state   <= r_mem_we ? DONE : WAIT;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_rdata   <= 32'd0;
            r_done    <= 1'b1;
            r_buserr  <= 1'b1;
            r_state   <= DONE;
          end
        end
        WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (mem_rvalid) begin
            r_rdata <= w_ld_data;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_rdata  <= 32'd0;
            r_done   <= 1'b1;
            r_buserr <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stallM;
  logic [31:0] rdata;
  logic        done;
  logic        adel;
  logic        ades;
  logic        buserr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  mem_lsu #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stallM       (stallM),
    .rdata        (rdata),
    .done         (done),
    .adel         (adel),
    .ades         (ades),
    .buserr       (buserr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL tb_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait memory: grant and rvalid held high; returns how many cycles stallM was high.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, output int stall_cyc);
    int n;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
    stall_cyc = 0;
    n = 0;
    #1;
    while (!done && n < 20) begin
      if (stallM) stall_cyc++;
      cyc();
      n++;
    end
    chk("xact_done", {31'd0, done}, 32'd1);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    cyc();
  endtask

  initial begin
    int sc;
    int n;
    int reqc;
    int seen;
    int grants;
    int dones;
    int d1;
    int d2;

    #1 rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_buserr", {31'd0, buserr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cyc();

    // store byte, zero-wait
    xact(1'b1, 2'b00, 1'b0, 32'h1002, 32'h000000AB, 32'd0, sc);
    chk("sb_stall_cycles", sc, 32'd2);
    chk("sb_mem_addr", mem_addr, 32'h1000);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h4);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_mem_we", {31'd0, mem_we}, 32'd1);

    // signed half load, grant on second REQ cycle, rvalid one cycle after grant
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h2002; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h8001FFFF;
    #1 chk("lh_idle_stall", {31'd0, stallM}, 32'd1);
    cyc();
    chk("lh_req", {31'd0, mem_req}, 32'd1);
    chk("lh_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("lh_mem_addr", mem_addr, 32'h2000);
    cyc();
    mem_gnt = 1'b1;
    chk("lh_req2_stall", {31'd0, stallM}, 32'd1);
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    chk("lh_wait_req", {31'd0, mem_req}, 32'd0);
    chk("lh_wait_stall", {31'd0, stallM}, 32'd1);
    cyc();
    mem_rvalid = 1'b0;
    chk("lh_done", {31'd0, done}, 32'd1);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    chk("lh_done_stall", {31'd0, stallM}, 32'd0);
    req_unsigned = 1'b1;
    cyc();
    chk("lhu_idle_stall", {31'd0, stallM}, 32'd1);
    cyc();
    cyc();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    chk("lhu_rdata_hold", rdata, 32'hFFFF8001);
    cyc();
    mem_rvalid = 1'b0;
    chk("lhu_done", {31'd0, done}, 32'd1);
    chk("lhu_rdata", rdata, 32'h00008001);
    req_valid = 1'b0;
    cyc();

    // lane selection and store formatting
    xact(1'b0, 2'b00, 1'b0, 32'h2001, 32'd0, 32'h12349A78, sc);
    chk("lb_lane1", rdata, 32'hFFFFFF9A);
    xact(1'b0, 2'b00, 1'b1, 32'h2003, 32'd0, 32'h12349A78, sc);
    chk("lbu_lane3", rdata, 32'h00000012);
    xact(1'b0, 2'b10, 1'b0, 32'h2004, 32'd0, 32'hDEADBEEF, sc);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_stall_cycles", sc, 32'd3);
    chk("lw_wstrb", {28'd0, mem_wstrb}, 32'd0);
    xact(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234CAFE, 32'd0, sc);
    chk("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCAFECAFE);
    xact(1'b1, 2'b00, 1'b0, 32'h2003, 32'h00000055, 32'd0, sc);
    chk("sb3_wstrb", {28'd0, mem_wstrb}, 32'h8);
    xact(1'b1, 2'b10, 1'b0, 32'h0040, 32'h01020304, 32'd0, sc);
    chk("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'h01020304);
    chk("rdata_hold_over_store", rdata, 32'hDEADBEEF);

    // misaligned word load, then misaligned half store
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h3001;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    #1;
    chk("mis_adel", {31'd0, adel}, 32'd1);
    chk("mis_ades_lw", {31'd0, ades}, 32'd0);
    chk("mis_stall_lw", {31'd0, stallM}, 32'd0);
    seen = 0;
    repeat (3) begin
      cyc();
      if (mem_req || stallM) seen++;
    end
    chk("mis_no_req", seen, 32'd0);
    req_we = 1'b1; req_size = 2'b01; req_addr = 32'h3003;
    #1;
    chk("mis_ades", {31'd0, ades}, 32'd1);
    chk("mis_adel_sh", {31'd0, adel}, 32'd0);
    chk("mis_stall_sh", {31'd0, stallM}, 32'd0);
    cyc();
    chk("mis_sh_no_req", {31'd0, mem_req}, 32'd0);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    cyc();

    // watchdog: grant never comes
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h50;
    n = 0; reqc = 0;
    #1;
    while (!done && n < 30) begin
      if (mem_req) reqc++;
      cyc();
      n++;
    end
    chk("wd_req_cycles", reqc, 32'd8);
    chk("wd_done", {31'd0, done}, 32'd1);
    chk("wd_buserr", {31'd0, buserr}, 32'd1);
    chk("wd_rdata", rdata, 32'd0);
    chk("wd_mem_req", {31'd0, mem_req}, 32'd0);
    req_valid = 1'b0;
    cyc();
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFFFFFF;
    cyc();
    chk("late_buserr", {31'd0, buserr}, 32'd0);
    chk("late_done", {31'd0, done}, 32'd0);
    chk("late_rdata", rdata, 32'd0);
    chk("late_mem_req", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    cyc();

    // back-to-back lw then sw with req_valid held high
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    n = 0; grants = 0; dones = 0; d1 = -1; d2 = -1;
    #1;
    while (dones < 2 && n < 30) begin
      if (mem_req && mem_gnt) grants++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          d1 = n;
          req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hA5A5A5A5;
        end else begin
          d2 = n;
        end
      end
      if (dones < 2) begin
        cyc();
        n++;
      end
    end
    chk("b2b_grants", grants, 32'd2);
    chk("b2b_dones", dones, 32'd2);
    chk("b2b_first_done", d1, 32'd3);
    chk("b2b_second_done", d2, 32'd6);
    chk("b2b_rdata", rdata, 32'h11223344);
    chk("b2b_mem_addr", mem_addr, 32'h14);
    chk("b2b_wstrb", {28'd0, mem_wstrb}, 32'hF);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    cyc();

    // reset while waiting for read data
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h60;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    cyc();
    cyc();
    chk("rw_pre_stall", {31'd0, stallM}, 32'd1);
    chk("rw_pre_addr", mem_addr, 32'h60);
    #1 rst = 1'b0;
    #1;
    chk("rw_stall", {31'd0, stallM}, 32'd0);
    chk("rw_mem_addr", mem_addr, 32'd0);
    chk("rw_rdata", rdata, 32'd0);
    chk("rw_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rw_done", {31'd0, done}, 32'd0);
    req_valid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk) rst = 1'b1;
    cyc();
    xact(1'b0, 2'b10, 1'b0, 32'h64, 32'd0, 32'hCAFEF00D, sc);
    chk("post_rst_rdata", rdata, 32'hCAFEF00D);
    chk("post_rst_cycles", sc, 32'd3);
    chk("post_rst_addr", mem_addr, 32'h64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
